tpu_mac: RTL and testbench
==========================

# tpu_mac

Signed multiply-accumulate processing element for a systolic-array matrix multiplier. Each cycle it forwards its A operand east and its B operand south through registers. It accumulates `A*B` into a local C register. The C register can be preloaded, or shifted through from a neighbour, by a write enable.

## Interface
Parameters:
- `BITS_AB`, default 8: width of the signed A/B operands.
- `BITS_C`, default 16: width of the signed accumulator and the C ports.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  enables A/B forwarding and accumulation.
- `WrEn`  in  1  loads `Cin` into the accumulator.
- `Ain`  in  BITS_AB  signed A operand.
- `Bin`  in  BITS_AB  signed B operand.
- `Cin`  in  BITS_C  signed accumulator load value.
- `Aout`  out  BITS_AB  registered `Ain`.
- `Bout`  out  BITS_AB  registered `Bin`.
- `Cout`  out  BITS_C  accumulator register.

## Operation
- Reset (`rst`=1) immediately clears `Aout`, `Bout` and `Cout` to 0, independent of `clk`.
- Register updates on each rising edge, in priority order:
  - `WrEn`=1: `Cout <= Cin`. This applies regardless of `en`.
  - Else `en`=1: `Cout <= Cout + Ain*Bin`.
  - Else: `Cout` holds.
- `en`=1: `Aout <= Ain`, `Bout <= Bin`. `en`=0: both hold. `WrEn` does not affect `Aout`/`Bout`.
- Arithmetic:
  - Product is a signed `BITS_AB x BITS_AB` multiply, full `2*BITS_AB`-bit result.
  - The product is sign-extended or truncated to `BITS_C` before the add.
  - The sum wraps modulo `2^BITS_C` (two's complement), unless saturation is configured.
- All outputs come directly from registers; there is no combinational path from input to output.

## Timing
- Latency is 1 cycle. Operands present before edge k appear in `Cout`, `Aout` and `Bout` after edge k.
- Cycle 0 after reset release with `en`=1: `Cout` reads 0 until the first accumulating edge.
- `WrEn` and `en` asserted together: the load wins and no product is added that cycle.
- Reset asserted mid-accumulation clears state at once. The first edge after release accumulates from 0.
- No handshake. Inputs must be stable around each rising edge.

## Configuration
- Macro `TPUMAC_SATURATE_EN`.
- Defined: the accumulate saturates to `+(2^(BITS_C-1)-1)` or `-2^(BITS_C-1)` on signed overflow.
- Undefined: the accumulate wraps modulo `2^BITS_C`.
- The `WrEn` load is never saturated.

## Structure
- Package `tpu_pkg` holds:
  - default constants `BITS_AB`=8 and `BITS_C`=16;
  - typedefs `ab_t` (signed `[BITS_AB-1:0]`) and `c_t` (signed `[BITS_C-1:0]`);
  - saturation limit constants.
- One sub-module, `tpu_mac_acc`: combinational signed multiply plus add, with the optional saturation logic under the macro.
- The top level keeps the three registers and the priority logic.

## Test plan
- Reset: assert `rst` with arbitrary inputs -> `Aout`=`Bout`=`Cout`=0 immediately, with no clock edge required.
- Sequence: release reset, `en`=1, `WrEn`=0, `Ain`=`Bin`=1..8 on successive edges -> `Cout` after each edge = 1, 5, 14, 30, 55, 91, 140, 204. `Aout` and `Bout` track the previous inputs.
- Load: `WrEn`=1, `en`=1, `Cin`=2 -> `Cout`=2 after the edge; no product added that cycle.
- Hold: `en`=0, `WrEn`=0, new `Ain`/`Bin` -> `Cout`, `Aout` and `Bout` unchanged.
- Signed operands: from 0, `Ain`=-3, `Bin`=5 -> `Cout`=-15. Then `Ain`=-4, `Bin`=-4 -> `Cout`=1.
- Overflow: load `Cin`=32767, then `Ain`=`Bin`=1 -> `Cout`=-32768, or 32767 with `TPUMAC_SATURATE_EN`.
- Mid-operation reset: assert `rst` between edges -> `Cout`=0 immediately; accumulation restarts from 0 after release.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and types for the tpu_mac processing element.
// Saturating accumulate is selected with the TPUMAC_SATURATE_EN macro.
package tpu_pkg;

    localparam int unsigned BITS_AB = 8;
    localparam int unsigned BITS_C  = 16;

    typedef logic signed [BITS_AB-1:0] ab_t;
    typedef logic signed [BITS_C-1:0]  c_t;

    // Saturation limits for the default accumulator width
    localparam c_t SAT_MAX_C = {1'b0, {(BITS_C-1){1'b1}}};
    localparam c_t SAT_MIN_C = {1'b1, {(BITS_C-1){1'b0}}};

endpackage

// File: rtl/tpu_mac_acc.sv
// Combinational signed multiply-add for the MAC accumulator.
// With TPUMAC_SATURATE_EN defined the add clamps on signed overflow,
// otherwise it wraps modulo 2^BITS_C.
module tpu_mac_acc #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned BITS_C  = tpu_pkg::BITS_C
) (
    input  logic signed [BITS_AB-1:0] a_i,
    input  logic signed [BITS_AB-1:0] b_i,
    input  logic signed [BITS_C-1:0]  acc_i,
    output logic signed [BITS_C-1:0]  sum_c
);
    import tpu_pkg::*;

    localparam int unsigned PW = 2 * BITS_AB;

    logic signed [PW-1:0]     prod;
    logic signed [BITS_C-1:0] prod_ext;
    logic signed [BITS_C-1:0] raw_sum;

    // Full-width signed product, resized (sign-extend or truncate) and added
    always_comb begin
        prod     = PW'(a_i) * PW'(b_i);
        prod_ext = BITS_C'(prod);
        raw_sum  = acc_i + prod_ext;
    end

`ifdef TPUMAC_SATURATE_EN
    localparam logic signed [BITS_C-1:0] SAT_MAX = {1'b0, {(BITS_C-1){1'b1}}};
    localparam logic signed [BITS_C-1:0] SAT_MIN = {1'b1, {(BITS_C-1){1'b0}}};

    logic ovf;

    // Overflow only when both addends share a sign the result does not
    always_comb begin
        ovf = (acc_i[BITS_C-1] == prod_ext[BITS_C-1]) &&
              (raw_sum[BITS_C-1] != acc_i[BITS_C-1]);
        if (ovf) begin
            sum_c = acc_i[BITS_C-1] ? SAT_MIN : SAT_MAX;
        end else begin
            sum_c = raw_sum;
        end
    end
`else
    // Two's complement wrap
    always_comb begin
        sum_c = raw_sum;
    end
`endif

endmodule

// File: rtl/tpu_mac.sv
// Systolic-array MAC processing element: forwards A east and B south
// through registers and accumulates A*B into a local C register that can
// be loaded from Cin. Optional saturation: define TPUMAC_SATURATE_EN.
module tpu_mac #(
    parameter int unsigned BITS_AB = tpu_pkg::BITS_AB,
    parameter int unsigned BITS_C  = tpu_pkg::BITS_C
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] Ain,
    input  logic signed [BITS_AB-1:0] Bin,
    input  logic signed [BITS_C-1:0]  Cin,
    output logic signed [BITS_AB-1:0] Aout,
    output logic signed [BITS_AB-1:0] Bout,
    output logic signed [BITS_C-1:0]  Cout
);
    import tpu_pkg::*;

    logic signed [BITS_AB-1:0] a_q, a_d;
    logic signed [BITS_AB-1:0] b_q, b_d;
    logic signed [BITS_C-1:0]  c_q, c_d;
    logic signed [BITS_C-1:0]  acc_sum_c;

    tpu_mac_acc #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C)
    ) u_acc (
        .a_i   (Ain),
        .b_i   (Bin),
        .acc_i (c_q),
        .sum_c (acc_sum_c)
    );

    // Next-state: load beats accumulate; forwarding follows en only
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        if (en) begin
            a_d = Ain;
            b_d = Bin;
        end
        if (WrEn) begin
            c_d = Cin;
        end else if (en) begin
            c_d = acc_sum_c;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
        end
    end

    assign Aout = a_q;
    assign Bout = b_q;
    assign Cout = c_q;

endmodule

// File: tb/tb_tpu_mac.sv
// Directed self-checking bench for tpu_mac (default 8/16-bit widths).
module tb_tpu_mac;

    logic              clk;
    logic              rst;
    logic              en;
    logic              WrEn;
    logic signed [7:0]  Ain;
    logic signed [7:0]  Bin;
    logic signed [15:0] Cin;
    logic signed [7:0]  Aout;
    logic signed [7:0]  Bout;
    logic signed [15:0] Cout;

    int n_cmp;
    int n_fail;

    tpu_mac #(
        .BITS_AB (8),
        .BITS_C  (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .WrEn (WrEn),
        .Ain  (Ain),
        .Bin  (Bin),
        .Cin  (Cin),
        .Aout (Aout),
        .Bout (Bout),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ea, input int eb, input int ec);
        chk({tag, "_A"}, 32'(Aout), ea);
        chk({tag, "_B"}, 32'(Bout), eb);
        chk({tag, "_C"}, 32'(Cout), ec);
    endtask

    // Advance one rising edge and land 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq_exp[8];
        int ovf_pos;
        int ovf_neg;
        int big_wrap;
        seq_exp = '{1, 5, 14, 30, 55, 91, 140, 204};
`ifdef TPUMAC_SATURATE_EN
        ovf_pos  = 32767;
        ovf_neg  = -32768;
        big_wrap = 32767;
`else
        ovf_pos  = -32768;
        ovf_neg  = 32767;
        big_wrap = -32768;
`endif
        n_cmp  = 0;
        n_fail = 0;

        // Reset with arbitrary inputs, checked before any clock edge
        rst  = 1'b1;
        en   = 1'b1;
        WrEn = 1'b0;
        Ain  = 8'sd77;
        Bin  = -8'sd19;
        Cin  = 16'sd1234;
        #2;
        chk_all("reset_async", 0, 0, 0);
        step();
        step();
        chk_all("reset_held", 0, 0, 0);

        // Release and verify nothing accumulated yet
        rst = 1'b0;
        Ain = 8'sd1;
        Bin = 8'sd1;
        #1;
        chk("post_release_C", 32'(Cout), 0);

        // Sum of squares sequence
        for (int i = 1; i <= 8; i++) begin
            Ain = 8'(i);
            Bin = 8'(i);
            step();
            chk_all($sformatf("seq%0d", i), i, i, seq_exp[i-1]);
        end

        // Load wins over accumulate; forwarding still happens
        WrEn = 1'b1;
        en   = 1'b1;
        Cin  = 16'sd2;
        Ain  = 8'sd9;
        Bin  = 8'sd9;
        step();
        chk_all("load", 9, 9, 2);

        // Hold
        WrEn = 1'b0;
        en   = 1'b0;
        Ain  = 8'sd7;
        Bin  = 8'sd3;
        step();
        chk_all("hold", 9, 9, 2);

        // Load with en=0 does not forward
        WrEn = 1'b1;
        Cin  = 16'sd0;
        step();
        chk_all("load_noen", 9, 9, 0);

        // Signed operands
        WrEn = 1'b0;
        en   = 1'b1;
        Ain  = -8'sd3;
        Bin  = 8'sd5;
        step();
        chk_all("signed1", -3, 5, -15);
        Ain = -8'sd4;
        Bin = -8'sd4;
        step();
        chk_all("signed2", -4, -4, 1);

        // Positive overflow
        WrEn = 1'b1;
        Cin  = 16'sd32767;
        step();
        chk("ovf_load", 32'(Cout), 32767);
        WrEn = 1'b0;
        Ain  = 8'sd1;
        Bin  = 8'sd1;
        step();
        chk("ovf_pos", 32'(Cout), ovf_pos);

        // Negative overflow
        WrEn = 1'b1;
        Cin  = -16'sd32768;
        step();
        WrEn = 1'b0;
        Ain  = -8'sd1;
        Bin  = 8'sd1;
        step();
        chk("ovf_neg", 32'(Cout), ovf_neg);

        // Largest product (-128*-128) twice from zero
        WrEn = 1'b1;
        Cin  = 16'sd0;
        step();
        WrEn = 1'b0;
        Ain  = -8'sd128;
        Bin  = -8'sd128;
        step();
        chk("big1", 32'(Cout), 16384);
        step();
        chk("big2", 32'(Cout), big_wrap);

        // Mid-operation reset
        WrEn = 1'b1;
        Cin  = 16'sd100;
        step();
        WrEn = 1'b0;
        Ain  = 8'sd2;
        Bin  = 8'sd3;
        step();
        chk("pre_rst", 32'(Cout), 106);
        rst = 1'b1;
        #1;
        chk_all("mid_rst", 0, 0, 0);
        #1;
        rst = 1'b0;
        step();
        chk_all("restart", 2, 3, 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
